// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 raster constants and small helpers for the timing generator
// and the graphics blocks that consume its pixel coordinates.
package video_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int REFR_ROW = V_ACTIVE + 1;
    localparam int MAX_X    = H_ACTIVE;
    localparam int MAX_Y    = V_ACTIVE;

    localparam int CNT_W    = 10;
    localparam int DIV_W    = 4;
    localparam int CNT_MAX  = 1 << CNT_W;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } sync_bus_t;

    function automatic bit fits_counter(input int total);
        return (total >= 1) && (total <= CNT_MAX);
    endfunction

    // Window bounds are one bit wider so a sync that ends exactly at 1024 still decodes.
    function automatic logic sync_level(input logic [CNT_W-1:0] cnt,
                                        input logic [CNT_W:0]   start,
                                        input logic [CNT_W:0]   stop,
                                        input logic             pol);
        logic in_win;
        in_win = ({1'b0, cnt} >= start) && ({1'b0, cnt} < stop);
        return in_win ? pol : ~pol;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// DLY-deep shift register with a per-bit reset value; DLY=0 collapses to a wire.
module sync_delay_line #(
    parameter int             DLY     = 1,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (DLY == 0) begin : g_pass
        assign dout = din;
    end else begin : g_shift
        logic [W-1:0] stage [DLY];

        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int i = 0; i < DLY; i++) begin
                    stage[i] <= RST_VAL;
                end
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DLY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DLY-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel divider, h/v counters, registered coordinate and
// sync decode, frame refresh tick, and a delayed sync/DE path for downstream colour.
module video_timing_gen #(
    parameter int   H_ACTIVE = video_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = video_timing_pkg::H_FP,
    parameter int   H_SYNC   = video_timing_pkg::H_SYNC,
    parameter int   H_BP     = video_timing_pkg::H_BP,
    parameter int   V_ACTIVE = video_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = video_timing_pkg::V_FP,
    parameter int   V_SYNC   = video_timing_pkg::V_SYNC,
    parameter int   V_BP     = video_timing_pkg::V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIX_DIV  = 1,
    parameter int   SYNC_DLY = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       refr_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       hsync_d,
    output logic       vsync_d
);

    import video_timing_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (!fits_counter(H_TOT) || !fits_counter(V_TOT)) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL and V_TOTAL must each be at most 1024");
    end
    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
        $error("video_timing_gen: PIX_DIV must be in 1..16");
    end
    if (SYNC_DLY < 0 || SYNC_DLY > 7) begin : g_bad_dly
        $error("video_timing_gen: SYNC_DLY must be in 0..7");
    end

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] REFR_PREV = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W:0]   HS_START  = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   HS_STOP   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VS_START  = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   VS_STOP   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             tick;
    logic             line_end;

    // Tick is gated by reset so it reads low while reset is held, even with PIX_DIV=1.
    assign tick     = reset && (div_cnt == DIV_LAST);
    assign line_end = (h_cnt == H_LAST);
    assign p_tick   = tick;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // Registered view of the counters; refr_tick lands in the cycle the counters reach
    // (0, V_ACTIVE+1), so the coordinates show that row one clk later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_x     <= '0;
            pix_y     <= '0;
            video_on  <= 1'b0;
            hsync     <= ~HS_POL;
            vsync     <= ~VS_POL;
            refr_tick <= 1'b0;
        end else begin
            pix_x     <= h_cnt;
            pix_y     <= v_cnt;
            video_on  <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
            hsync     <= sync_level(h_cnt, HS_START, HS_STOP, HS_POL);
            vsync     <= sync_level(v_cnt, VS_START, VS_STOP, VS_POL);
            refr_tick <= tick && line_end && (v_cnt == REFR_PREV);
        end
    end

    sync_bus_t sync_now;
    sync_bus_t sync_late;

    assign sync_now = '{de: video_on, hsync: hsync, vsync: vsync};

    sync_delay_line #(
        .DLY     (SYNC_DLY),
        .W       ($bits(sync_bus_t)),
        .RST_VAL ({1'b0, ~HS_POL, ~VS_POL})
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   (sync_now),
        .dout  (sync_late)
    );

    assign de      = sync_late.de;
    assign hsync_d = sync_late.hsync;
    assign vsync_d = sync_late.vsync;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator that drives the pixel-coordinate interface the graphics blocks consume. It produces pix_x, pix_y, video_on, a per-frame refresh tick, and HDMI/VGA sync strobes, all from one clock. It sits between the clock/reset logic and the pong graphics and animation logic and the TMDS encoder. It also provides a delayed sync/DE path so the syncs stay aligned with pixel colour produced downstream.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480: visible lines
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical front porch / sync / back porch, in lines
- HS_POL, 0 / VS_POL, 0: active level of hsync / vsync
- PIX_DIV, 1: clk cycles per pixel, range 1..16
- SYNC_DLY, 1: extra clk cycles on the de/hsync_d/vsync_d path, range 0..7

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk rising edge)
- p_tick  out  1  pixel enable, one clk wide
- pix_x  out  10  current column, 0..H_TOTAL-1
- pix_y  out  10  current row, 0..V_TOTAL-1
- video_on  out  1  pix_x<H_ACTIVE and pix_y<V_ACTIVE
- refr_tick  out  1  one-clk pulse per frame at the start of vertical blanking
- hsync, vsync  out  1  syncs aligned with pix_x/pix_y
- de, hsync_d, vsync_d  out  1  video_on/hsync/vsync delayed by SYNC_DLY clk cycles

## Operation
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525). H_TOTAL and V_TOTAL must each be ≤1024; elaboration fails otherwise.
- Divider: div_cnt runs 0..PIX_DIV-1. p_tick=1 in the cycle where div_cnt==PIX_DIV-1. With PIX_DIV=1, p_tick is high every cycle after reset.
- On p_tick, h_cnt increments and wraps H_TOTAL-1→0. On that wrap, v_cnt increments and wraps V_TOTAL-1→0.
- Counters hold their value between p_ticks.
- Decode of the counters:
  - hsync=HS_POL while H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vsync is decoded the same way on v_cnt with V_* and VS_POL.
- refr_tick: one clk pulse on the p_tick where the counters become h=0, v=V_ACTIVE+1 (row 481 by default). Exactly one pulse per frame.
- All counter arithmetic is 10-bit unsigned. Sync window compares are unsigned against elaboration-time constants.

## Timing
- Reset values: div_cnt, h_cnt, v_cnt = 0; pix_x = pix_y = 0; video_on = 0; p_tick = 0; refr_tick = 0; hsync = ~HS_POL; vsync = ~VS_POL.
- Reset values for the delay path: de = 0, hsync_d = ~HS_POL, vsync_d = ~VS_POL, and all delay-line stages are cleared.
- Output latency: pix_x, pix_y, video_on, hsync and vsync are registered and reflect the counter state of the previous clk. The first clk after reset release shows pix_x=0, pix_y=0, video_on=1.
- These outputs update only in the clk following a p_tick. They are stable for PIX_DIV clks per pixel.
- de, hsync_d and vsync_d equal video_on, hsync and vsync from SYNC_DLY clks earlier. SYNC_DLY=0 makes them combinational copies.
- Reset asserted mid-frame: every output returns to its reset value on the next edge and the frame restarts at (0,0). No partial refr_tick is emitted.
- A line wrap and a frame wrap in the same p_tick is legal: (H_TOTAL-1, V_TOTAL-1)→(0,0).

## Structure
- Shared package video_timing_pkg holds the 640x480@60 constants (H_ACTIVE, H_FP, H_SYNC, H_BP, V_*, the totals, and REFR_ROW=V_ACTIVE+1). The graphics blocks import MAX_X/MAX_Y from the same package.
- One sub-module: sync_delay_line, a parameterised DLY-deep shift register for {de, hsync, vsync} with a per-bit reset value. It is instantiated once.

## Test plan
- PIX_DIV=1, defaults, reset released: hsync is low for pix_x 656..751 (96 clks) with an 800-clk line period; vsync is low only on rows 490..491; 420000 clks per frame.
- video_on high exactly for x<640 and y<480; 307200 active clks per frame; pix_x=639→640 drops video_on on the following clk.
- refr_tick fires once per frame, with pix_x=0 and pix_y=481 on the clk after it; the spacing between pulses is 420000 clks.
- PIX_DIV=4: p_tick high every 4th clk; each pix_x value is held 4 clks; frame = 1680000 clks; sync widths scale ×4.
- Reset pulled low at pix_x=300, pix_y=200 for 3 clks: all outputs take their reset values; after release, the counters restart at (0,0) with no refr_tick glitch.
- SYNC_DLY=3: de, hsync_d and vsync_d equal video_on, hsync and vsync delayed by exactly 3 clks, including across a frame wrap.
